pipeline_controller: RTL and testbench

Central hazard and sequencing controller for the 5-stage cpu_pipelined datapath (IF/ID/EX/MEM/WB).
- Detects load-use hazards and taken-branch redirects, and drives the PC-write, IF/ID-write and IF/ID / ID/EX flush controls.
- Detects the halt sentinel word in ID, drains the pipeline, then raises a sticky end_program.
- Keeps cycle, stall and flush performance counters for the bench to read.

---
 rtl/pipeline_controller.sv | 118 +++++++++++
 tb/tb_pipeline_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Hazard, halt-drain and performance-count controller for the 5-stage pipeline.
// Resolves branch flushes, load-use stalls and the halt sequence into pipeline enables.
module pipeline_controller #(
  parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instr,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             end_program,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // A zero-length drain would skip retirement entirely, so it is promoted to one cycle.
  localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int DW        = (DRAIN_EFF > 1) ? $clog2(DRAIN_EFF) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_EFF - 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t        state, next_state;
  logic [DW-1:0] drain_cnt, drain_next;
  logic          br, lu, hl;
  logic          inc_cycle, inc_stall, inc_flush;

  always_comb begin
    br = ex_branch_taken;
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    hl = (id_instr == HALT_WORD);
  end

  always_comb begin
    next_state = state;
    drain_next = drain_cnt;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b1;
    inc_cycle  = 1'b0;
    inc_stall  = 1'b0;
    inc_flush  = 1'b0;
    case (state)
      RUN: begin
        inc_cycle = 1'b1;
        if (br) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          inc_flush  = 1'b1;
        end else if (lu) begin
          inc_stall = 1'b1;
        end else if (hl) begin
          next_state = DRAIN;
          drain_next = DRAIN_LOAD;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          idex_flush = 1'b0;
        end
      end
      DRAIN: begin
        inc_cycle = 1'b1;
        if (drain_cnt == '0) next_state = DONE;
        else                 drain_next = drain_cnt - DW'(1);
      end
      DONE:    next_state = DONE;
      default: next_state = RUN;
    endcase
    // Hold the front end frozen and bubbled while the datapath is in reset.
    if (!reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      drain_cnt   <= '0;
      end_program <= 1'b0;
    end else begin
      state     <= next_state;
      drain_cnt <= drain_next;
      if (next_state == DONE) end_program <= 1'b1;
    end
  end

  // Counters saturate so a long run never appears to restart from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (inc_cycle && (cycle_count != '1)) cycle_count <= cycle_count + CNT_W'(1);
      if (inc_stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (inc_flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a cycle-level reference model is compared
// on every falling edge, with hand-computed literal checks at key points.
module tb_pipeline_controller;
  localparam logic [31:0] HALT  = 32'hFFFFFFFF;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int          DRAIN = 3;

  logic        clk, reset;
  logic [31:0] id_instr;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, end_program;
  logic [31:0] cycle_count, stall_count, flush_count;

  pipeline_controller #(.HALT_WORD(HALT), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .end_program(end_program), .cycle_count(cycle_count), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: halted flag, remaining drain cycles and plain integer counters.
  bit     mDone = 1'b0;
  int     mDrainLeft = 0;
  longint mCycles = 0, mStalls = 0, mFlushes = 0;

  function automatic longint satInc(input longint v);
    return (v >= 64'hFFFFFFFF) ? v : v + 1;
  endfunction

  function automatic bit isBr();
    return ex_branch_taken;
  endfunction

  function automatic bit isLu();
    return ex_mem_read && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit isHl();
    return id_instr == HALT;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mDone <= 1'b0; mDrainLeft <= 0; mCycles <= 0; mStalls <= 0; mFlushes <= 0;
    end else if (!mDone) begin
      mCycles <= satInc(mCycles);
      if (mDrainLeft > 0) begin
        mDrainLeft <= mDrainLeft - 1;
        if (mDrainLeft == 1) mDone <= 1'b1;
      end else if (isBr()) mFlushes <= satInc(mFlushes);
      else if (isLu())     mStalls  <= satInc(mStalls);
      else if (isHl())     mDrainLeft <= DRAIN;
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp;
    if (started) begin
      if (!reset)                        exp = 4'b0011;
      else if (mDone || mDrainLeft > 0)  exp = 4'b0001;
      else if (isBr())                   exp = 4'b1111;
      else if (isLu() || isHl())         exp = 4'b0001;
      else                               exp = 4'b1100;
      checkOutput("ctrl{pc,ifid,ifflush,idflush}",
                  32'({pc_write, ifid_write, ifid_flush, idex_flush}), 32'(exp));
      checkOutput("end_program", 32'(end_program), 32'(mDone));
      checkOutput("cycle_count", cycle_count, mCycles[31:0]);
      checkOutput("stall_count", stall_count, mStalls[31:0]);
      checkOutput("flush_count", flush_count, mFlushes[31:0]);
    end
  end

  task automatic driveInputs(input logic [31:0] instr, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic mr,
                             input logic [4:0] rd, input logic bt);
    id_instr = instr; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_mem_read = mr; ex_rd = rd; ex_branch_taken = bt;
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mr,
                               input logic [4:0] rd, input logic bt);
    driveInputs(instr, rs1, rs2, u1, u2, mr, rd, bt);
    waitEdge();
  endtask

  initial begin
    reset = 1'b1;
    driveInputs(NOP, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    #1 reset = 1'b0;
    started = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    checkOutput("reset pc_write", 32'(pc_write), 32'd0);
    checkOutput("reset ifid_flush", 32'(ifid_flush), 32'd1);
    checkOutput("reset idex_flush", 32'(idex_flush), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("release pc_write", 32'(pc_write), 32'd1);
    checkOutput("release cycle_count", cycle_count, 32'd0);

    for (int i = 0; i < 3; i++) applyStimulus(NOP, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    checkOutput("benign cycle_count", cycle_count, 32'd3);

    driveInputs(NOP, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    #1;
    checkOutput("lu pc_write", 32'(pc_write), 32'd0);
    checkOutput("lu idex_flush", 32'(idex_flush), 32'd1);
    waitEdge();
    checkOutput("lu stall_count", stall_count, 32'd1);

    driveInputs(NOP, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
    #1;
    checkOutput("rd0 pc_write", 32'(pc_write), 32'd1);
    waitEdge();
    checkOutput("rd0 stall_count", stall_count, 32'd1);

    driveInputs(NOP, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1);
    #1;
    checkOutput("br ifid_flush", 32'(ifid_flush), 32'd1);
    checkOutput("br pc_write", 32'(pc_write), 32'd1);
    waitEdge();
    checkOutput("br flush_count", flush_count, 32'd1);
    checkOutput("br stall_count", stall_count, 32'd1);

    applyStimulus(HALT, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
    checkOutput("halt+br flush_count", flush_count, 32'd2);
    checkOutput("halt+br end_program", 32'(end_program), 32'd0);
    driveInputs(NOP, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    #1;
    checkOutput("halt+br still RUN", 32'(pc_write), 32'd1);
    waitEdge();

    driveInputs(HALT, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0);
    #1;
    checkOutput("halt pc_write", 32'(pc_write), 32'd0);
    waitEdge();
    checkOutput("halt cycle_count", cycle_count, 32'd9);
    driveInputs(NOP, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1);
    #1;
    checkOutput("drain ignores br", 32'(ifid_flush), 32'd0);
    waitEdge();
    applyStimulus(NOP, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    checkOutput("edge3 end_program", 32'(end_program), 32'd0);
    waitEdge();
    checkOutput("edge4 end_program", 32'(end_program), 32'd1);
    checkOutput("done cycle_count", cycle_count, 32'd12);
    checkOutput("done flush_count", flush_count, 32'd2);
    applyStimulus(NOP, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1);
    waitEdge();
    checkOutput("frozen cycle_count", cycle_count, 32'd12);
    checkOutput("sticky end_program", 32'(end_program), 32'd1);

    driveInputs(NOP, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("done reset end_program", 32'(end_program), 32'd0);
    checkOutput("done reset cycle_count", cycle_count, 32'd0);
    waitEdge();
    reset = 1'b1;
    applyStimulus(NOP, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    checkOutput("rerun cycle_count", cycle_count, 32'd1);
    applyStimulus(HALT, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0);
    applyStimulus(NOP, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("drain reset end_program", 32'(end_program), 32'd0);
    checkOutput("drain reset cycle_count", cycle_count, 32'd0);
    checkOutput("drain reset idex_flush", 32'(idex_flush), 32'd1);
    waitEdge();
    reset = 1'b1;
    applyStimulus(NOP, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
    checkOutput("post-reset RUN pc_write", 32'(pc_write), 32'd1);
    applyStimulus(HALT, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0);
    for (int e = 2; e <= 4; e++) begin
      applyStimulus(NOP, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
      checkOutput("second halt end_program", 32'(end_program), (e == 4) ? 32'd1 : 32'd0);
    end
    checkOutput("second halt cycle_count", cycle_count, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
